// File: rtl/ad_buff_fifo.sv
// ADC sample packer: captures N samples into 2-sample words and pushes them
// through an auto-draining show-ahead FIFO.
module ad_buff_fifo #(
    parameter int AD_DATA_SIZE = 8,
    parameter int FIFO_AW      = 10
) (
    input  logic                      i_ad_clk,
    input  logic                      i_rst_n,
    input  logic                      i_st,
    input  logic [15:0]               i_recv_count,
    input  logic [AD_DATA_SIZE-1:0]   i_ad_data,
    output logic [2*AD_DATA_SIZE-1:0] o_dual_data,
    output logic                      o_data_on,
    output logic                      o_working,
    output logic [2*AD_DATA_SIZE-1:0] o_rd_data,
    output logic                      o_empty,
    output logic                      o_full
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_COLLECT,
        S_END
    } state_t;

    localparam int DEPTH = 1 << FIFO_AW;

    state_t                    r_state;
    logic [15:0]               r_count_n;
    logic [15:0]               r_sample_cnt;
    logic [AD_DATA_SIZE-1:0]   r_hi;
    logic                      w_last;

    logic [2*AD_DATA_SIZE-1:0] r_mem [DEPTH];
    logic [FIFO_AW:0]          r_wr_ptr;
    logic [FIFO_AW:0]          r_rd_ptr;
    logic                      w_wr_en;
    logic                      w_rd_en;

    assign w_last = (r_sample_cnt == (r_count_n - 16'd1));

    // An odd-length capture flushes its last sample as a half word on the final edge
    always_ff @(posedge i_ad_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_count_n    <= '0;
            r_sample_cnt <= '0;
            r_hi         <= '0;
            o_dual_data  <= '0;
            o_data_on    <= 1'b0;
            o_working    <= 1'b0;
        end else begin
            o_data_on <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_st) begin
                        r_count_n    <= i_recv_count;
                        r_sample_cnt <= '0;
                        o_working    <= 1'b1;
                        r_state      <= S_START;
                    end
                end
                S_START: begin
                    if (r_count_n == 16'd0) begin
                        o_working <= 1'b0;
                        r_state   <= S_END;
                    end else begin
                        r_state <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    r_sample_cnt <= r_sample_cnt + 16'd1;
                    if (!r_sample_cnt[0]) begin
                        r_hi <= i_ad_data;
                        if (w_last) begin
                            o_dual_data <= {i_ad_data, {AD_DATA_SIZE{1'b0}}};
                            o_data_on   <= 1'b1;
                        end
                    end else begin
                        o_dual_data <= {r_hi, i_ad_data};
                        o_data_on   <= 1'b1;
                    end
                    if (w_last) begin
                        o_working <= 1'b0;
                        r_state   <= S_END;
                    end
                end
                S_END: begin
                    if (!i_st) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Extra MSB on each pointer separates full from empty when the indices match
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[FIFO_AW] != r_rd_ptr[FIFO_AW]) &&
                       (r_wr_ptr[FIFO_AW-1:0] == r_rd_ptr[FIFO_AW-1:0]);
    assign w_wr_en   = o_data_on && !o_full;
    assign w_rd_en   = !o_empty;
    assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr[FIFO_AW-1:0]];

    always_ff @(posedge i_ad_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge i_ad_clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[FIFO_AW-1:0]] <= o_dual_data;
        end
    end

endmodule

// File: tb/tb_ad_buff_fifo.sv
// Self-checking bench for ad_buff_fifo: directed table, randomized captures
// against a packing model, and reset-abort sequence.
module tb_ad_buff_fifo;

    localparam int DW = 8;

    logic            i_ad_clk = 1'b0;
    logic            i_rst_n;
    logic            i_st;
    logic [15:0]     i_recv_count;
    logic [DW-1:0]   i_ad_data;
    logic [2*DW-1:0] o_dual_data;
    logic            o_data_on;
    logic            o_working;
    logic [2*DW-1:0] o_rd_data;
    logic            o_empty;
    logic            o_full;

    ad_buff_fifo #(.AD_DATA_SIZE(DW), .FIFO_AW(2)) dut (
        .i_ad_clk    (i_ad_clk),
        .i_rst_n     (i_rst_n),
        .i_st        (i_st),
        .i_recv_count(i_recv_count),
        .i_ad_data   (i_ad_data),
        .o_dual_data (o_dual_data),
        .o_data_on   (o_data_on),
        .o_working   (o_working),
        .o_rd_data   (o_rd_data),
        .o_empty     (o_empty),
        .o_full      (o_full)
    );

    always #5 i_ad_clk = ~i_ad_clk;

    typedef struct {
        int          n;
        logic [31:0] samples;
        logic [15:0] w0;
        logic [15:0] w1;
        int          hold;
    } vec_t;

    vec_t            vecs[6];
    int              checks = 0;
    int              errors = 0;
    logic [15:0]     pairQ[$];
    logic [15:0]     rdQ[$];
    logic [15:0]     expQ[$];
    logic [7:0]      sampleQ[$];
    int              workCycles;
    logic            prevWorking;
    logic            fallPulse;
    logic            fullSeen;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    // Advance one clock and record what the DUT showed in the new cycle
    task automatic step();
        @(posedge i_ad_clk);
        #1;
        if (o_data_on) pairQ.push_back(o_dual_data);
        if (!o_empty) rdQ.push_back(o_rd_data);
        if (o_working) workCycles++;
        if (o_full) fullSeen = 1'b1;
        if (prevWorking && !o_working) fallPulse = o_data_on;
        prevWorking = o_working;
    endtask

    // Reference: consecutive samples pair up high-then-low, odd tail padded with zero
    task automatic buildModel();
        int n;
        n = sampleQ.size();
        expQ.delete();
        for (int i = 0; i < n; i += 2) begin
            logic [7:0] lo;
            lo = (i + 1 < n) ? sampleQ[i+1] : 8'h00;
            expQ.push_back({sampleQ[i], lo});
        end
    endtask

    task automatic applyStimulus(input int n, input int hold);
        pairQ.delete();
        rdQ.delete();
        workCycles  = 0;
        fallPulse   = 1'b0;
        fullSeen    = 1'b0;
        prevWorking = o_working;
        i_st         = 1'b1;
        i_recv_count = n[15:0];
        i_ad_data    = 8'($urandom);
        step();
        i_recv_count = 16'($urandom);
        step();
        for (int k = 0; k < n; k++) begin
            i_ad_data = sampleQ[k];
            step();
        end
        i_ad_data = 8'($urandom);
        for (int i = 0; i < 4 + hold; i++) step();
        i_st = 1'b0;
        step();
        step();
    endtask

    task automatic verifyCapture(input string tag, input int n);
        logic [15:0] got;
        checkOutput({tag, " pulses"}, pairQ.size(), expQ.size());
        for (int i = 0; i < expQ.size(); i++) begin
            got = (i < pairQ.size()) ? pairQ[i] : 16'hxxxx;
            checkOutput($sformatf("%s pair%0d", tag, i), {16'h0, got}, {16'h0, expQ[i]});
        end
        checkOutput({tag, " rd count"}, rdQ.size(), expQ.size());
        for (int i = 0; i < expQ.size(); i++) begin
            got = (i < rdQ.size()) ? rdQ[i] : 16'hxxxx;
            checkOutput($sformatf("%s rd%0d", tag, i), {16'h0, got}, {16'h0, expQ[i]});
        end
        checkOutput({tag, " working cycles"}, workCycles, n + 1);
        checkOutput({tag, " fall with pulse"}, {31'h0, fallPulse}, (n > 0) ? 32'd1 : 32'd0);
        checkOutput({tag, " empty after"}, {31'h0, o_empty}, 32'd1);
        checkOutput({tag, " full seen"}, {31'h0, fullSeen}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{n: 4, samples: 32'h11223344, w0: 16'h1122, w1: 16'h3344, hold: 0};
        vecs[1] = '{n: 3, samples: 32'hA1B2C300, w0: 16'hA1B2, w1: 16'hC300, hold: 0};
        vecs[2] = '{n: 1, samples: 32'h5A000000, w0: 16'h5A00, w1: 16'h0000, hold: 0};
        vecs[3] = '{n: 0, samples: 32'h00000000, w0: 16'h0000, w1: 16'h0000, hold: 3};
        vecs[4] = '{n: 2, samples: 32'h7E810000, w0: 16'h7E81, w1: 16'h0000, hold: 20};
        vecs[5] = '{n: 2, samples: 32'hC0DE0000, w0: 16'hC0DE, w1: 16'h0000, hold: 0};

        i_rst_n      = 1'b0;
        i_st         = 1'b0;
        i_recv_count = 16'd0;
        i_ad_data    = 8'd0;
        prevWorking  = 1'b0;
        #3;
        checkOutput("reset working", {31'h0, o_working}, 32'd0);
        checkOutput("reset data_on", {31'h0, o_data_on}, 32'd0);
        checkOutput("reset dual", {16'h0, o_dual_data}, 32'd0);
        checkOutput("reset empty", {31'h0, o_empty}, 32'd1);
        checkOutput("reset full", {31'h0, o_full}, 32'd0);
        checkOutput("reset rd", {16'h0, o_rd_data}, 32'd0);
        step();
        step();
        i_rst_n = 1'b1;
        step();

        for (int v = 0; v < 6; v++) begin
            sampleQ.delete();
            for (int k = 0; k < vecs[v].n; k++) begin
                logic [31:0] s;
                s = vecs[v].samples;
                sampleQ.push_back(s[31-8*k -: 8]);
            end
            applyStimulus(vecs[v].n, vecs[v].hold);
            expQ.delete();
            if (vecs[v].n > 0) expQ.push_back(vecs[v].w0);
            if (vecs[v].n > 2) expQ.push_back(vecs[v].w1);
            verifyCapture($sformatf("vec%0d", v), vecs[v].n);
        end

        // Randomized lengths including odd ones, plus the deep wrap case of 16
        for (int r = 0; r < 7; r++) begin
            int n;
            n = (r == 0) ? 16 : int'($urandom_range(0, 40));
            sampleQ.delete();
            for (int k = 0; k < n; k++) sampleQ.push_back(8'($urandom));
            applyStimulus(n, int'($urandom_range(0, 3)));
            buildModel();
            verifyCapture($sformatf("rand%0d n%0d", r, n), n);
        end

        // Reset in the middle of a long capture
        i_st         = 1'b1;
        i_recv_count = 16'd100;
        step();
        step();
        for (int k = 0; k < 10; k++) begin
            i_ad_data = 8'($urandom);
            step();
        end
        i_rst_n = 1'b0;
        #1;
        checkOutput("abort working", {31'h0, o_working}, 32'd0);
        checkOutput("abort data_on", {31'h0, o_data_on}, 32'd0);
        checkOutput("abort dual", {16'h0, o_dual_data}, 32'd0);
        checkOutput("abort empty", {31'h0, o_empty}, 32'd1);
        checkOutput("abort rd", {16'h0, o_rd_data}, 32'd0);
        i_st = 1'b0;
        step();
        step();
        i_rst_n = 1'b1;
        workCycles = 0;
        for (int i = 0; i < 3; i++) step();
        checkOutput("idle after abort", workCycles, 0);
        checkOutput("empty after abort", {31'h0, o_empty}, 32'd1);

        sampleQ.delete();
        for (int k = 0; k < 5; k++) sampleQ.push_back(8'($urandom));
        applyStimulus(5, 0);
        buildModel();
        verifyCapture("post-abort", 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
